// File: rtl/capture_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : capture_sequencer_if
//  Description : Sample-stream, SPRAM and UART-transmit signal bundle for the
//                triggered I/Q snapshot sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface capture_sequencer_if #(
    parameter int AW = 8
);
    logic          arm;
    logic          abort;
    logic          sample_stb;
    logic [7:0]    i_value;
    logic [7:0]    q_value;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic          ram_wren;
    logic [15:0]   ram_rdata;
    logic [7:0]    tx_dat;
    logic          tx_start;
    logic          tx_busy;
    logic          armed;
    logic          done;

    // Sequencer side
    modport slave (
        input  arm, abort, sample_stb, i_value, q_value, ram_rdata, tx_busy,
        output ram_addr, ram_wdata, ram_wren, tx_dat, tx_start, armed, done
    );

    // Controller / environment side
    modport master (
        output arm, abort, sample_stb, i_value, q_value, ram_rdata, tx_busy,
        input  ram_addr, ram_wdata, ram_wren, tx_dat, tx_start, armed, done
    );
endinterface
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : capture_sequencer
//  Description : Re-armable triggered I/Q capture into SPRAM followed by a
//                UART dump (sync byte, then I/Q bytes in address order).
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer #(
    parameter int         DEPTH  = 256,
    parameter int         AW     = 8,
    parameter logic [8:0] THRESH = 9'd64,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    capture_sequencer_if.slave   bus
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TRIG = 3'd1,
        S_CAPTURE   = 3'd2,
        S_RD        = 3'd3,
        S_SEND      = 3'd4,
        S_WAIT_TX   = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t        state_q;
    logic [AW-1:0] ram_addr_q;
    logic [15:0]   ram_wdata_q;
    logic          ram_wren_q;
    logic [7:0]    tx_dat_q;
    logic          tx_start_q;
    logic          armed_q;
    logic          done_q;
    logic          sync_q;    // next byte to send is the sync byte
    logic          hi_q;      // byte phase: 0 = I (low), 1 = Q (high)
    logic          guard_q;   // first WAIT_TX cycle, tx_busy not yet valid

    // Saturating magnitude so that -128 maps to 127 and |I|+|Q| fits 254
    function automatic logic [7:0] abs_sat(input logic [7:0] v);
        if (v == 8'h80)
            return 8'd127;
        else if (v[7])
            return 8'd0 - v;
        else
            return v;
    endfunction

    logic [8:0] mag;
    logic       trig;
    assign mag  = {1'b0, abs_sat(bus.i_value)} + {1'b0, abs_sat(bus.q_value)};
    assign trig = bus.sample_stb && (mag >= THRESH);

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_wren  = ram_wren_q;
    assign bus.tx_dat    = tx_dat_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.armed     = armed_q;
    assign bus.done      = done_q;

    // Sequencer FSM: trigger, capture, then byte-by-byte UART dump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wren_q  <= 1'b0;
            tx_dat_q    <= '0;
            tx_start_q  <= 1'b0;
            armed_q     <= 1'b0;
            done_q      <= 1'b0;
            sync_q      <= 1'b0;
            hi_q        <= 1'b0;
            guard_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below
            ram_wren_q <= 1'b0;
            tx_start_q <= 1'b0;
            if (bus.abort) begin
                state_q    <= S_IDLE;
                ram_addr_q <= '0;
                armed_q    <= 1'b0;
                done_q     <= 1'b0;
                sync_q     <= 1'b0;
                hi_q       <= 1'b0;
                guard_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        ram_addr_q <= '0;
                        if (bus.arm) begin
                            armed_q <= 1'b1;
                            state_q <= S_WAIT_TRIG;
                        end
                    end
                    S_WAIT_TRIG: begin
                        // Triggering sample becomes the write at address 0
                        if (trig) begin
                            ram_wren_q  <= 1'b1;
                            ram_wdata_q <= {bus.q_value, bus.i_value};
                            armed_q     <= 1'b0;
                            state_q     <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        // ram_addr advances after each write so that
                        // back-to-back strobes land on consecutive addresses
                        if (ram_wren_q && ram_addr_q == LAST_ADDR) begin
                            ram_addr_q <= '0;
                            sync_q     <= 1'b1;
                            hi_q       <= 1'b0;
                            state_q    <= S_RD;
                        end else begin
                            if (ram_wren_q)
                                ram_addr_q <= ram_addr_q + AW'(1);
                            if (bus.sample_stb) begin
                                ram_wren_q  <= 1'b1;
                                ram_wdata_q <= {bus.q_value, bus.i_value};
                            end
                        end
                    end
                    S_RD: begin
                        state_q <= S_SEND;
                    end
                    S_SEND: begin
                        if (!bus.tx_busy) begin
                            if (sync_q)
                                tx_dat_q <= SYNC;
                            else if (hi_q)
                                tx_dat_q <= bus.ram_rdata[15:8];
                            else
                                tx_dat_q <= bus.ram_rdata[7:0];
                            tx_start_q <= 1'b1;
                            guard_q    <= 1'b1;
                            state_q    <= S_WAIT_TX;
                        end
                    end
                    S_WAIT_TX: begin
                        if (guard_q) begin
                            guard_q <= 1'b0;
                        end else if (!bus.tx_busy) begin
                            if (sync_q) begin
                                sync_q  <= 1'b0;
                                hi_q    <= 1'b0;
                                state_q <= S_RD;
                            end else if (!hi_q) begin
                                // Same word still on ram_rdata, no re-read
                                hi_q    <= 1'b1;
                                state_q <= S_SEND;
                            end else if (ram_addr_q != LAST_ADDR) begin
                                hi_q       <= 1'b0;
                                ram_addr_q <= ram_addr_q + AW'(1);
                                state_q    <= S_RD;
                            end else begin
                                hi_q    <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        if (bus.arm) begin
                            ram_addr_q <= '0;
                            done_q     <= 1'b0;
                            armed_q    <= 1'b1;
                            state_q    <= S_WAIT_TRIG;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_sequencer
//  Description : Scoreboard bench for capture_sequencer with SPRAM and UART
//                behavioural models; two extra instances probe the trigger
//                threshold boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       arm = 1'b0, arm_x = 1'b0, abort = 1'b0, stb = 1'b0;
    logic [7:0] iv = 8'h00, qv = 8'h00;

    int total = 0, bad = 0, n_tx = 0, base = 0;
    int busy_len = 3;
    int busy_cnt = 0;

    logic [7:0]  exp_tx[$];
    logic [17:0] exp_wr[$];
    logic [7:0]  e8;
    logic [17:0] e18;
    logic [15:0] mem [4];

    logic [7:0] dump1 [9] = '{8'hA5, 8'hD8, 8'hE2, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] dump2 [9] = '{8'hA5, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'h00, 8'h80, 8'h40, 8'hC0};
    logic [7:0] dump3 [3] = '{8'hA5, 8'h64, 8'h00};
    logic [7:0] dump4 [9] = '{8'hA5, 8'hBA, 8'h00, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04};

    capture_sequencer_if #(.AW(2)) m_if ();
    capture_sequencer_if #(.AW(2)) a_if ();
    capture_sequencer_if #(.AW(2)) b_if ();

    assign m_if.arm = arm;   assign m_if.abort = abort; assign m_if.sample_stb = stb;
    assign m_if.i_value = iv; assign m_if.q_value = qv;
    assign m_if.tx_busy = (busy_cnt != 0);

    assign a_if.arm = arm_x; assign a_if.abort = abort; assign a_if.sample_stb = stb;
    assign a_if.i_value = iv; assign a_if.q_value = qv;
    assign a_if.ram_rdata = 16'h0000; assign a_if.tx_busy = 1'b0;

    assign b_if.arm = arm_x; assign b_if.abort = abort; assign b_if.sample_stb = stb;
    assign b_if.i_value = iv; assign b_if.q_value = qv;
    assign b_if.ram_rdata = 16'h0000; assign b_if.tx_busy = 1'b0;

    capture_sequencer #(.DEPTH(4), .AW(2), .THRESH(9'd64), .SYNC(8'hA5)) u_main (
        .clk(clk), .rst_n(rst_n), .bus(m_if.slave));
    capture_sequencer #(.DEPTH(4), .AW(2), .THRESH(9'd254), .SYNC(8'hA5)) u_t254 (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    capture_sequencer #(.DEPTH(4), .AW(2), .THRESH(9'd255), .SYNC(8'hA5)) u_t255 (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    // SPRAM (one-cycle read latency) and acia_tx busy model
    always @(posedge clk) begin
        if (m_if.ram_wren) mem[m_if.ram_addr] <= m_if.ram_wdata;
        m_if.ram_rdata <= mem[m_if.ram_addr];
        if (m_if.tx_start)   busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes SPRAM or starts a byte
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.tx_start) begin
                n_tx++;
                check("tx_start_while_busy", {31'd0, m_if.tx_busy}, 32'd0);
                if (exp_tx.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected got=%0h want=none", m_if.tx_dat);
                end else begin
                    e8 = exp_tx.pop_front();
                    check("tx_byte", {24'd0, m_if.tx_dat}, {24'd0, e8});
                end
            end
            if (m_if.ram_wren) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected got=%0h want=none", {m_if.ram_addr, m_if.ram_wdata});
                end else begin
                    e18 = exp_wr.pop_front();
                    check("ram_write", {14'd0, m_if.ram_addr, m_if.ram_wdata}, {14'd0, e18});
                end
            end
        end
    end

    task automatic send(input logic [7:0] i, input logic [7:0] q);
        @(negedge clk); stb = 1'b1; iv = i; qv = q;
        @(negedge clk); stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_wr(input logic [1:0] a, input logic [7:0] i, input logic [7:0] q);
        exp_wr.push_back({a, q, i});
    endtask

    task automatic pulse_arm();
        @(negedge clk); arm = 1'b1; @(negedge clk); arm = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk); abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!m_if.done && n < bound) begin @(negedge clk); n++; end
        check("done_reached", {31'd0, m_if.done}, 32'd1);
    endtask

    function automatic logic [31:0] outs();
        return {18'd0, m_if.ram_addr, m_if.ram_wren, m_if.tx_start, m_if.tx_dat, m_if.armed, m_if.done};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 32'd0);
        rst_n = 1'b1;

        // Threshold trigger, capture, dump with short busy
        base = n_tx;
        pulse_arm();
        check("armed_after_arm", {31'd0, m_if.armed}, 32'd1);
        send(8'h0A, 8'h0A);
        check("below_thresh_armed", {31'd0, m_if.armed}, 32'd1);
        expect_wr(2'd0, 8'hD8, 8'hE2); send(8'hD8, 8'hE2);
        check("armed_cleared_on_trig", {31'd0, m_if.armed}, 32'd0);
        expect_wr(2'd1, 8'h01, 8'h02); send(8'h01, 8'h02);
        pulse_arm();
        expect_wr(2'd2, 8'h03, 8'h04); send(8'h03, 8'h04);
        foreach (dump1[k]) exp_tx.push_back(dump1[k]);
        expect_wr(2'd3, 8'h05, 8'h06); send(8'h05, 8'h06);
        wait_done(400);
        repeat (20) @(negedge clk);
        check("dump1_len", n_tx - base, 9);
        check("done_held", {31'd0, m_if.done}, 32'd1);

        // Long busy, re-arm from DONE, arm during capture ignored
        busy_len = 100;
        base = n_tx;
        pulse_arm();
        check("rearm_done_clr", {30'd0, m_if.done, m_if.armed}, 32'd1);
        foreach (dump2[k]) exp_tx.push_back(dump2[k]);
        expect_wr(2'd0, 8'hFF, 8'h7F); send(8'hFF, 8'h7F);
        expect_wr(2'd1, 8'h80, 8'h00); send(8'h80, 8'h00);
        pulse_arm();
        expect_wr(2'd2, 8'h00, 8'h80); send(8'h00, 8'h80);
        expect_wr(2'd3, 8'h40, 8'hC0); send(8'h40, 8'hC0);
        wait_done(3000);
        check("dump2_len", n_tx - base, 9);

        // Abort after the third byte, then recapture from address 0
        busy_len = 3;
        base = n_tx;
        pulse_arm();
        foreach (dump3[k]) exp_tx.push_back(dump3[k]);
        expect_wr(2'd0, 8'h64, 8'h00); send(8'h64, 8'h00);
        expect_wr(2'd1, 8'h01, 8'h01); send(8'h01, 8'h01);
        expect_wr(2'd2, 8'h02, 8'h02); send(8'h02, 8'h02);
        expect_wr(2'd3, 8'h03, 8'h03); send(8'h03, 8'h03);
        for (int n = 0; n < 300 && (n_tx - base) < 3; n++) @(negedge clk);
        check("third_byte_seen", n_tx - base, 3);
        pulse_abort();
        check("abort_idle", {28'd0, m_if.armed, m_if.done, m_if.tx_start, m_if.ram_wren}, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_more_tx", n_tx - base, 3);
        base = n_tx;
        pulse_arm();
        foreach (dump4[k]) exp_tx.push_back(dump4[k]);
        expect_wr(2'd0, 8'hBA, 8'h00); send(8'hBA, 8'h00);
        expect_wr(2'd1, 8'h09, 8'h08); send(8'h09, 8'h08);
        expect_wr(2'd2, 8'h07, 8'h06); send(8'h07, 8'h06);
        expect_wr(2'd3, 8'h05, 8'h04); send(8'h05, 8'h04);
        wait_done(400);
        check("dump4_len", n_tx - base, 9);

        // Threshold boundary: 254 triggers on (-128,-128), 255 never does
        pulse_abort();
        @(negedge clk); arm_x = 1'b1; @(negedge clk); arm_x = 1'b0;
        check("aux_armed", {29'd0, a_if.armed, b_if.armed, m_if.armed}, 32'd6);
        send(8'h64, 8'h64);
        check("aux_still_armed", {30'd0, a_if.armed, b_if.armed}, 32'd3);
        @(negedge clk); stb = 1'b1; iv = 8'h80; qv = 8'h80;
        @(negedge clk); stb = 1'b0;
        check("t254_write", {15'd0, a_if.ram_wren, a_if.ram_wdata}, 32'h18080);
        check("t255_no_write", {31'd0, b_if.ram_wren}, 32'd0);
        repeat (5) @(negedge clk);
        check("t254_t255_armed", {30'd0, a_if.armed, b_if.armed}, 32'd1);
        pulse_abort();

        // Asynchronous reset in the middle of a capture
        pulse_arm();
        expect_wr(2'd0, 8'hD8, 8'hE2); send(8'hD8, 8'hE2);
        expect_wr(2'd1, 8'h11, 8'h22); send(8'h11, 8'h22);
        check("capture_addr_nonzero", {30'd0, m_if.ram_addr}, 32'd2);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs(), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h64, 8'h64);
        repeat (5) @(negedge clk);
        check("idle_after_reset", {30'd0, m_if.armed, m_if.done}, 32'd0);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("tx_queue_empty", exp_tx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
